// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, op encoding
// and helpers for deriving and validating the chunk width.
package pipelined_adder_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 4;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Chunk width; guarded so a bad STAGES=0 does not divide by zero
    // before the geometry check gets a chance to report it.
    function automatic int unsigned chunk_width(input int unsigned width,
                                                input int unsigned stages);
        return (stages == 0) ? width : width / stages;
    endfunction

    function automatic bit geometry_ok(input int unsigned width,
                                       input int unsigned stages);
        return (stages >= 1) && ((width % stages) == 0);
    endfunction

    localparam int unsigned CW = chunk_width(DEF_WIDTH, DEF_STAGES);

endpackage

// File: rtl/pipelined_adder_stage.sv
// One chunk of the carry chain: adds a CHUNK_W-bit slice plus incoming carry
// and registers the sum slice, carry and valid bit when enabled.
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned CHUNK_W = CW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic               valid_i,
    input  logic [CHUNK_W-1:0] a_i,
    input  logic [CHUNK_W-1:0] b_i,
    input  logic               carry_i,
    output logic               valid_o,
    output logic [CHUNK_W-1:0] sum_o,
    output logic               carry_o
);

    logic [CHUNK_W-1:0] sum_d;
    logic [CHUNK_W-1:0] sum_q;
    logic               carry_d;
    logic               carry_q;
    logic               valid_d;
    logic               valid_q;

    // Chunk adder with carry-in; the extra MSB is the chunk carry-out.
    always_comb begin
        {carry_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK_W{1'b0}}, carry_i};
        valid_d          = valid_i;
    end

    // Stage register; holds everything while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract with valid/ready handshake. One chunk of
// the carry chain is resolved per cycle; operands are skewed in and sum
// chunks de-skewed out so the full result exits in one beat.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned CHUNK_W = chunk_width(WIDTH, STAGES);

    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic               advance;
    op_e                op;
    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;

    logic [CHUNK_W-1:0] op_a      [STAGES];
    logic [CHUNK_W-1:0] op_b      [STAGES];
    logic               st_cin    [STAGES];
    logic               st_vin    [STAGES];
    logic               st_vout   [STAGES];
    logic [CHUNK_W-1:0] st_sum    [STAGES];
    logic               st_carry  [STAGES];
    logic [CHUNK_W-1:0] out_chunk [STAGES];

    logic               a_msb_d;
    logic               a_msb_q;
    logic               b_msb_d;
    logic               b_msb_q;

    // The whole pipeline moves as one; it only stops when a result is stuck.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = st_vout[STAGES-1];
    assign carry_out = st_carry[STAGES-1];

    // Subtraction is a + ~b + !borrow_in, so fold the op into B and carry-in.
    always_comb begin
        op      = op_e'(sub);
        b_eff   = (op == OP_SUB) ? ~b : b;
        cin_eff = (op == OP_SUB) ? !carry_in : carry_in;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        if (k == 0) begin : g_head
            assign op_a[k]   = a[CHUNK_W-1:0];
            assign op_b[k]   = b_eff[CHUNK_W-1:0];
            assign st_cin[k] = cin_eff;
            assign st_vin[k] = in_valid;
        end else begin : g_skew
            // Chunk k must wait k cycles for its carry, so delay its operands by k.
            logic [CHUNK_W-1:0] a_sk_q [k];
            logic [CHUNK_W-1:0] b_sk_q [k];

            // Operand skew shift register for this chunk.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned j = 0; j < k; j++) begin
                        a_sk_q[j] <= '0;
                        b_sk_q[j] <= '0;
                    end
                end else if (advance) begin
                    a_sk_q[0] <= a[k*CHUNK_W +: CHUNK_W];
                    b_sk_q[0] <= b_eff[k*CHUNK_W +: CHUNK_W];
                    for (int unsigned j = 1; j < k; j++) begin
                        a_sk_q[j] <= a_sk_q[j-1];
                        b_sk_q[j] <= b_sk_q[j-1];
                    end
                end
            end

            assign op_a[k]   = a_sk_q[k-1];
            assign op_b[k]   = b_sk_q[k-1];
            assign st_cin[k] = st_carry[k-1];
            assign st_vin[k] = st_vout[k-1];
        end

        pipelined_adder_stage #(
            .CHUNK_W (CHUNK_W)
        ) u_stage (
            .clk     (clk),
            .rst     (reset),
            .en_i    (advance),
            .valid_i (st_vin[k]),
            .a_i     (op_a[k]),
            .b_i     (op_b[k]),
            .carry_i (st_cin[k]),
            .valid_o (st_vout[k]),
            .sum_o   (st_sum[k]),
            .carry_o (st_carry[k])
        );

        localparam int unsigned DS = STAGES - 1 - k;

        if (DS == 0) begin : g_direct
            assign out_chunk[k] = st_sum[k];
        end else begin : g_deskew
            // Chunk k finishes early; hold it back DS cycles to align with the top chunk.
            logic [CHUNK_W-1:0] ds_q [DS];

            // Sum de-skew shift register for this chunk.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int unsigned j = 0; j < DS; j++) begin
                        ds_q[j] <= '0;
                    end
                end else if (advance) begin
                    ds_q[0] <= st_sum[k];
                    for (int unsigned j = 1; j < DS; j++) begin
                        ds_q[j] <= ds_q[j-1];
                    end
                end
            end

            assign out_chunk[k] = ds_q[DS-1];
        end
    end

    // Reassemble the aligned chunks into the full-width result.
    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            sum[k*CHUNK_W +: CHUNK_W] = out_chunk[k];
        end
    end

    // Operand sign bits as seen by the top chunk, captured alongside its sum.
    always_comb begin
        a_msb_d = op_a[STAGES-1][CHUNK_W-1];
        b_msb_d = op_b[STAGES-1][CHUNK_W-1];
    end

    // Sign-bit registers travel with the top stage so overflow stays aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
        end else if (advance) begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
        end
    end

    assign overflow = (a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q);

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: the driver pushes reference results
// at acceptance, an independent monitor pops and compares on each output beat.
module tb_pipelined_adder;

    localparam int unsigned W = 32;
    localparam int unsigned S = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int unsigned  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;

    exp_t         sb_q[$];
    int unsigned  n_cmp = 0;
    int unsigned  n_bad = 0;
    int unsigned  cyc = 0;
    int unsigned  send_waits = 0;
    bit           check_lat = 1'b0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic [1:0]   held_flags;

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                   input logic tc, input logic ts, input int unsigned c);
        exp_t   e;
        longint ua, ub, sa, sbv, ci, u, s;
        ua  = longint'({32'b0, ta});
        ub  = longint'({32'b0, tb});
        sa  = longint'($signed(ta));
        sbv = longint'($signed(tb));
        ci  = tc ? 64'sd1 : 64'sd0;
        if (!ts) begin
            u      = ua + ub + ci;
            s      = sa + sbv + ci;
            e.cout = (u > 64'sd4294967295);
        end else begin
            u      = ua - ub - ci;
            s      = sa - sbv - ci;
            e.cout = (u >= 64'sd0);
        end
        e.sum = u[W-1:0];
        e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.cyc = c;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts);
        int unsigned w = 0;
        a        = ta;
        b        = tb;
        carry_in = tc;
        sub      = ts;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
        end else begin
            sb_q.push_back(model(ta, tb, tc, ts, cyc));
        end
        send_waits += w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int unsigned w = 0;
        while (sb_q.size() != 0 && w < 60) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: handshake rule, output hold under stall, and in-order results.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (stall_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_sum", 64'(sum), 64'(held_sum));
                chk("hold_flags", 64'({carry_out, overflow}), 64'(held_flags));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_output: got sum 0x%0h with no pending transaction, required none", sum);
                end else begin
                    e = sb_q.pop_front();
                    chk("sum", 64'(sum), 64'(e.sum));
                    chk("carry_out", 64'(carry_out), 64'(e.cout));
                    chk("overflow", 64'(overflow), 64'(e.ovf));
                    if (check_lat) chk("latency", 64'(cyc), 64'(e.cyc + S));
                end
            end
            stall_prev = out_valid && !out_ready;
            held_sum   = sum;
            held_flags = {carry_out, overflow};
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry", 64'(carry_out), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        idle(1);

        // Directed arithmetic corners.
        check_lat = 1'b1;
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        send(32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        drain();

        // Back-to-back random stream, consumer always ready.
        send_waits = 0;
        for (int i = 0; i < 20; i++) begin
            send($urandom(), $urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end
        drain();
        chk("stream_no_stall", 64'(send_waits), 64'd0);

        // Stream under consumer backpressure.
        check_lat = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send($urandom(), $urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check_lat = 1'b1;

        // Reset with transactions in flight.
        send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
        send(32'h0000_0030, 32'h0000_0040, 1'b0, 1'b0);
        a        = 32'h3;
        b        = 32'h3;
        in_valid = 1'b1;
        reset    = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_flags", 64'({carry_out, overflow}), 64'd0);
        in_valid = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
        drain();

        // Gapped input: bubbles must keep their spacing; chunk-boundary carries.
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        idle(1);
        send(32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        idle(2);
        send(32'h0001_0000, 32'h0000_0001, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            send($urandom(), $urandom(), 1'($urandom_range(1)), 1'($urandom_range(1)));
            idle(i % 3);
        end
        drain();

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
